// File: rtl/aes_seq_pkg.sv
// Shared types and sizes for the AES block sequencer.
package aes_seq_pkg;

  localparam int unsigned DWORD_W    = 32;
  localparam int unsigned BLOCK_W    = 128;
  localparam int unsigned LOAD_WORDS = 9;
  localparam int unsigned READ_WORDS = 4;
  localparam int unsigned REQ_WORDS  = (2 * BLOCK_W) / DWORD_W;
  localparam int unsigned SEL_W      = $clog2(REQ_WORDS);
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned TMO_W      = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT_DONE,
    ST_READ,
    ST_OUT,
    ST_ERR
  } state_e;

  // Captured host request; plaintext occupies the upper half so dword 0 is the MSBs.
  typedef struct packed {
    logic [BLOCK_W-1:0] pt;
    logic [BLOCK_W-1:0] key;
  } aes_req_t;

endpackage

// File: rtl/aes_dword_serializer.sv
// Selects one 32-bit word of the {plaintext, key} request; word 0 is the most significant.
module aes_dword_serializer
  import aes_seq_pkg::*;
(
  input  aes_req_t           req_i,
  input  logic [SEL_W-1:0]   sel_i,
  output logic [DWORD_W-1:0] dword_c
);

  localparam int unsigned REQ_W = $bits(aes_req_t);

  // Word mux indexed by the load counter.
  always_comb begin
    dword_c = '0;
    for (int unsigned i = 0; i < REQ_WORDS; i++) begin
      if (sel_i == SEL_W'(i)) dword_c = req_i[REQ_W-1-i*DWORD_W -: DWORD_W];
    end
  end

endmodule

// File: rtl/aes_block_sequencer.sv
// Sequences one AES block through a word-serial core: load, wait, read back, hand off.
// Optional feature macro AES_SEQ_TIMEOUT_EN adds a core_done watchdog and err_timeout port.
module aes_block_sequencer
  import aes_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 512
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_pt,
  input  logic [BLOCK_W-1:0] in_key,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_ct,
  output logic               core_start_n,
  output logic [DWORD_W-1:0] core_dword_in,
  input  logic               core_done,
  output logic               core_start_read_n,
  input  logic [DWORD_W-1:0] core_dword_out,
  output logic               busy
`ifdef AES_SEQ_TIMEOUT_EN
  ,
  output logic               err_timeout
`endif
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  aes_req_t           req_q, req_d;
  logic [BLOCK_W-1:0] ct_q, ct_d;
  logic [DWORD_W-1:0] dword_q, dword_d;
  logic               start_n_q, start_n_d;
  logic               start_read_n_q, start_read_n_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;
  logic               busy_q, busy_d;
  logic [SEL_W-1:0]   sel_c;
  logic [DWORD_W-1:0] ser_dword_c;
`ifdef AES_SEQ_TIMEOUT_EN
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               err_q, err_d;
`endif

  aes_dword_serializer u_serializer (
    .req_i   (req_d),
    .sel_i   (sel_c),
    .dword_c (ser_dword_c)
  );

  // Next state, datapath and registered outputs derived from the upcoming state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    ct_d    = ct_q;
`ifdef AES_SEQ_TIMEOUT_EN
    tmo_d   = tmo_q;
    err_d   = err_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          req_d   = '{pt: in_pt, key: in_key};
          cnt_d   = '0;
          state_d = ST_LOAD;
`ifdef AES_SEQ_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      ST_LOAD: begin
        if (cnt_q == CNT_W'(LOAD_WORDS - 1)) begin
          state_d = ST_WAIT_DONE;
          cnt_d   = '0;
`ifdef AES_SEQ_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (core_done) begin
          state_d = ST_READ;
          cnt_d   = '0;
        end
`ifdef AES_SEQ_TIMEOUT_EN
        else begin
          tmo_d = tmo_q + TMO_W'(1);
          if (tmo_d == TMO_W'(TIMEOUT_CYCLES)) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end
        end
`endif
      end
      ST_READ: begin
        // Core presents ciphertext word k-1 while cnt=k.
        for (int unsigned i = 0; i < READ_WORDS; i++) begin
          if (cnt_q == CNT_W'(i + 1)) ct_d[BLOCK_W-1-i*DWORD_W -: DWORD_W] = core_dword_out;
        end
        if (cnt_q == CNT_W'(READ_WORDS)) state_d = ST_OUT;
        else                             cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_OUT: begin
        if (out_valid_q && out_ready) state_d = ST_IDLE;
      end
      ST_ERR: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // LOAD cnt=0 and cnt=1 both present dword 0; WAIT_DONE keeps the last key word.
    if (state_d == ST_LOAD) sel_c = (cnt_d == '0) ? '0 : SEL_W'(cnt_d - CNT_W'(1));
    else                    sel_c = SEL_W'(REQ_WORDS - 1);

    dword_d        = (state_d == ST_LOAD || state_d == ST_WAIT_DONE) ? ser_dword_c : dword_q;
    start_n_d      = !(state_d == ST_LOAD && cnt_d == '0);
    start_read_n_d = !(state_d == ST_READ && cnt_d == '0);
    out_valid_d    = (state_d == ST_OUT);
    in_ready_d     = (state_d == ST_IDLE);
    busy_d         = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      req_q          <= '0;
      ct_q           <= '0;
      dword_q        <= '0;
      start_n_q      <= 1'b1;
      start_read_n_q <= 1'b1;
      out_valid_q    <= 1'b0;
      in_ready_q     <= 1'b0;
      busy_q         <= 1'b0;
`ifdef AES_SEQ_TIMEOUT_EN
      tmo_q          <= '0;
      err_q          <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      req_q          <= req_d;
      ct_q           <= ct_d;
      dword_q        <= dword_d;
      start_n_q      <= start_n_d;
      start_read_n_q <= start_read_n_d;
      out_valid_q    <= out_valid_d;
      in_ready_q     <= in_ready_d;
      busy_q         <= busy_d;
`ifdef AES_SEQ_TIMEOUT_EN
      tmo_q          <= tmo_d;
      err_q          <= err_d;
`endif
    end
  end

  assign in_ready          = in_ready_q;
  assign out_valid         = out_valid_q;
  assign out_ct            = ct_q;
  assign core_start_n      = start_n_q;
  assign core_dword_in     = dword_q;
  assign core_start_read_n = start_read_n_q;
  assign busy              = busy_q;
`ifdef AES_SEQ_TIMEOUT_EN
  assign err_timeout       = err_q;
`endif

endmodule
